// File: rtl/coprocessor_pio_pkg.sv
// Shared types, field map and constants for the Nios PIO coprocessor mailbox.
package coprocessor_pio_pkg;

  localparam int unsigned CP_ARG_W  = 24;
  localparam int unsigned CP_OPC_W  = 7;
  localparam int unsigned CP_STAT_W = 5;
  localparam int unsigned PIO_W     = 32;

  // pio_cmd field positions: [31]=req_tgl [30:24]=opcode [23:0]=arg
  localparam int unsigned CMD_TGL_BIT = 31;
  localparam int unsigned CMD_OPC_LSB = 24;
  localparam int unsigned CMD_ARG_LSB = 0;

  // pio_rsp field positions: [31]=ack_tgl [30]=busy [29]=err [28:24]=status [23:0]=result
  localparam int unsigned RSP_ACK_BIT  = 31;
  localparam int unsigned RSP_BUSY_BIT = 30;
  localparam int unsigned RSP_ERR_BIT  = 29;
  localparam int unsigned RSP_STAT_LSB = 24;
  localparam int unsigned RSP_RES_LSB  = 0;

  localparam logic [CP_STAT_W-1:0] STAT_TIMEOUT = 5'h1F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } ep_state_t;

  typedef struct packed {
    logic                 ack_tgl;
    logic                 busy;
    logic                 err;
    logic [CP_STAT_W-1:0] status;
    logic [CP_ARG_W-1:0]  result;
  } pio_rsp_t;

  // Assemble a response word from its fields.
  function automatic logic [PIO_W-1:0] pack_rsp(
    input logic                 ack_tgl,
    input logic                 busy,
    input logic                 err,
    input logic [CP_STAT_W-1:0] status,
    input logic [CP_ARG_W-1:0]  result
  );
    pio_rsp_t r;
    r.ack_tgl = ack_tgl;
    r.busy    = busy;
    r.err     = err;
    r.status  = status;
    r.result  = result;
    return r;
  endfunction

endpackage

// File: rtl/coprocessor_pio_if.sv
// Command/response handshake between the PIO endpoint (master) and the coprocessor core (slave).
interface coprocessor_pio_if;
  import coprocessor_pio_pkg::*;

  logic                 cp_cmd_valid;
  logic                 cp_cmd_ready;
  logic [CP_OPC_W-1:0]  cp_opcode;
  logic [CP_ARG_W-1:0]  cp_arg;
  logic                 cp_rsp_valid;
  logic                 cp_rsp_ready;
  logic [CP_ARG_W-1:0]  cp_rsp_data;
  logic [CP_STAT_W-1:0] cp_rsp_stat;

  modport master (
    output cp_cmd_valid, cp_opcode, cp_arg, cp_rsp_ready,
    input  cp_cmd_ready, cp_rsp_valid, cp_rsp_data, cp_rsp_stat
  );

  modport slave (
    input  cp_cmd_valid, cp_opcode, cp_arg, cp_rsp_ready,
    output cp_cmd_ready, cp_rsp_valid, cp_rsp_data, cp_rsp_stat
  );
endinterface

// File: rtl/coprocessor_pio_timeout.sv
// Loadable down-counter bounding how long the endpoint waits for a core response.
// Loading starts the window at TIMEOUT_CYC-1; expired_c flags the terminal count.
module coprocessor_pio_timeout #(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Count down while enabled, saturating at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired_c = (cnt == '0);

endmodule

// File: rtl/coprocessor_pio_endpoint.sv
// Coprocessor-side end of the Nios PIO mailbox: turns toggle-marked command words into
// valid/ready transactions to the core and posts result/status back on the PIO in_port.
module coprocessor_pio_endpoint
  import coprocessor_pio_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned ARG_W       = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PIO_W-1:0]     pio_cmd,
  output logic [PIO_W-1:0]     pio_rsp,
  coprocessor_pio_if.master    cp
);

  ep_state_t           state, state_nxt;
  logic                req_seen, req_seen_nxt;
  logic [CP_OPC_W-1:0] opcode_nxt;
  logic [ARG_W-1:0]    arg_nxt;
  logic [PIO_W-1:0]    rsp_nxt;
  logic                tmo_load, tmo_en, tmo_expired_c;

  coprocessor_pio_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .load      (tmo_load),
    .en        (tmo_en),
    .expired_c (tmo_expired_c)
  );

  // FSM state and last accepted request toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      req_seen <= 1'b0;
    end else begin
      state    <= state_nxt;
      req_seen <= req_seen_nxt;
    end
  end

  // Next-state, command latch and response-word decisions.
  always_comb begin
    state_nxt    = state;
    req_seen_nxt = req_seen;
    opcode_nxt   = cp.cp_opcode;
    arg_nxt      = cp.cp_arg;
    rsp_nxt      = pio_rsp;
    tmo_load     = 1'b0;
    tmo_en       = 1'b0;
    case (state)
      IDLE: begin
        // A late response from a timed-out command must drain before a new issue.
        if ((pio_cmd[CMD_TGL_BIT] != req_seen) && !cp.cp_rsp_valid) begin
          state_nxt             = ISSUE;
          req_seen_nxt          = pio_cmd[CMD_TGL_BIT];
          opcode_nxt            = pio_cmd[CMD_OPC_LSB +: CP_OPC_W];
          arg_nxt               = pio_cmd[CMD_ARG_LSB +: ARG_W];
          rsp_nxt[RSP_BUSY_BIT] = 1'b1;
        end
      end
      ISSUE: begin
        if (cp.cp_cmd_valid && cp.cp_cmd_ready) begin
          state_nxt = WAIT;
          tmo_load  = 1'b1;
        end
      end
      WAIT: begin
        tmo_en = 1'b1;
        if (cp.cp_rsp_valid && cp.cp_rsp_ready) begin
          state_nxt = DONE;
          rsp_nxt   = pack_rsp(req_seen, 1'b0, (cp.cp_rsp_stat != '0),
                               cp.cp_rsp_stat, cp.cp_rsp_data);
        end else if (tmo_expired_c) begin
          state_nxt = DONE;
          rsp_nxt   = pack_rsp(req_seen, 1'b0, 1'b1, STAT_TIMEOUT, '0);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered outputs; handshake strobes follow the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      cp.cp_cmd_valid <= 1'b0;
      cp.cp_rsp_ready <= 1'b0;
      cp.cp_opcode    <= '0;
      cp.cp_arg       <= '0;
      pio_rsp         <= '0;
    end else begin
      cp.cp_cmd_valid <= (state_nxt == ISSUE);
      cp.cp_rsp_ready <= (state_nxt == WAIT);
      cp.cp_opcode    <= opcode_nxt;
      cp.cp_arg       <= arg_nxt;
      pio_rsp         <= rsp_nxt;
    end
  end

endmodule

// File: tb/tb_coprocessor_pio_endpoint.sv
// Directed bench for coprocessor_pio_endpoint with a short timeout window.
module tb_coprocessor_pio_endpoint;
  import coprocessor_pio_pkg::*;

  localparam int unsigned TMO = 16;

  typedef struct {
    logic [31:0] cmd;
    int          delay;
    logic [23:0] data;
    logic [4:0]  stat;
    logic [31:0] exp_rsp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pio_cmd;
  logic [31:0] pio_rsp;

  coprocessor_pio_if cp_if();

  coprocessor_pio_endpoint #(
    .TIMEOUT_CYC (TMO),
    .ARG_W       (24)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pio_cmd (pio_cmd),
    .pio_rsp (pio_rsp),
    .cp      (cp_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction with the core accepting immediately.
  task automatic run_txn(input string tag, input logic [31:0] cmd, input int delay,
                         input logic [23:0] data, input logic [4:0] stat,
                         input logic [31:0] exp_rsp);
    int busy_low;
    busy_low = 0;
    cp_if.cp_cmd_ready = 1'b1;
    pio_cmd = cmd;
    tick();
    check($sformatf("%s valid_rise", tag), 32'(cp_if.cp_cmd_valid), 32'd1);
    check($sformatf("%s opcode", tag), 32'(cp_if.cp_opcode), 32'(cmd[CMD_OPC_LSB +: 7]));
    check($sformatf("%s arg", tag), 32'(cp_if.cp_arg), 32'(cmd[CMD_ARG_LSB +: 24]));
    for (int i = 0; i < 8 && !cp_if.cp_rsp_ready; i++) begin
      if (!pio_rsp[RSP_BUSY_BIT]) busy_low++;
      tick();
    end
    check($sformatf("%s rsp_ready", tag), 32'(cp_if.cp_rsp_ready), 32'd1);
    for (int i = 0; i < delay; i++) begin
      if (!pio_rsp[RSP_BUSY_BIT]) busy_low++;
      tick();
    end
    cp_if.cp_rsp_valid = 1'b1;
    cp_if.cp_rsp_data  = data;
    cp_if.cp_rsp_stat  = stat;
    if (!pio_rsp[RSP_BUSY_BIT]) busy_low++;
    tick();
    cp_if.cp_rsp_valid = 1'b0;
    check($sformatf("%s pio_rsp", tag), pio_rsp, exp_rsp);
    check($sformatf("%s busy_low_cycles", tag), 32'(busy_low), 32'd0);
    check($sformatf("%s rsp_ready_done", tag), 32'(cp_if.cp_rsp_ready), 32'd0);
    tick();
  endtask

  initial begin
    int cnt;

    // cmd, rsp delay, rsp data, rsp stat, expected final pio_rsp
    vecs[0] = '{32'h8A001234, 3,  24'h00ABCD, 5'h00, 32'h8000ABCD};
    vecs[1] = '{32'h15ABCDEF, 0,  24'h123456, 5'h00, 32'h00123456};
    vecs[2] = '{32'hFFFFFFFF, 5,  24'hFFFFFF, 5'h03, 32'hA3FFFFFF};
    vecs[3] = '{32'h00000001, 1,  24'h000000, 5'h1F, 32'h3F000000};
    vecs[4] = '{32'hC0800000, 12, 24'h0F0F0F, 5'h10, 32'hB00F0F0F};

    reset              = 1'b1;
    pio_cmd            = '0;
    cp_if.cp_cmd_ready = 1'b0;
    cp_if.cp_rsp_valid = 1'b0;
    cp_if.cp_rsp_data  = '0;
    cp_if.cp_rsp_stat  = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state and idle with no pending toggle
    check("reset cmd_valid", 32'(cp_if.cp_cmd_valid), 32'd0);
    check("reset rsp_ready", 32'(cp_if.cp_rsp_ready), 32'd0);
    check("reset pio_rsp", pio_rsp, 32'h0);
    check("reset opcode", 32'(cp_if.cp_opcode), 32'h0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cp_if.cp_cmd_valid) cnt++;
    end
    check("idle20 valid_cycles", 32'(cnt), 32'd0);
    check("idle20 pio_rsp", pio_rsp, 32'h0);

    // Table-driven transactions
    for (int v = 0; v < 5; v++) begin
      run_txn($sformatf("vec%0d", v), vecs[v].cmd, vecs[v].delay, vecs[v].data,
              vecs[v].stat, vecs[v].exp_rsp);
    end

    // Backpressure: ready low for 50 cycles, ISSUE holds with no timeout
    cp_if.cp_cmd_ready = 1'b0;
    pio_cmd = 32'h05000042;
    tick();
    check("bp valid_rise", 32'(cp_if.cp_cmd_valid), 32'd1);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!cp_if.cp_cmd_valid || cp_if.cp_rsp_ready) cnt++;
    end
    check("bp stuck_cycles", 32'(cnt), 32'd0);
    check("bp pio_rsp_busy", pio_rsp, 32'hF00F0F0F);
    check("bp arg_stable", 32'(cp_if.cp_arg), 32'h000042);
    cp_if.cp_cmd_ready = 1'b1;
    tick();
    check("bp wait_rsp_ready", 32'(cp_if.cp_rsp_ready), 32'd1);
    check("bp wait_valid_low", 32'(cp_if.cp_cmd_valid), 32'd0);
    cp_if.cp_rsp_valid = 1'b1;
    cp_if.cp_rsp_data  = 24'h000777;
    cp_if.cp_rsp_stat  = 5'h00;
    tick();
    cp_if.cp_rsp_valid = 1'b0;
    check("bp pio_rsp", pio_rsp, 32'h00000777);
    tick();

    // Timeout: no response, result lands 16 cycles after the handshake edge
    pio_cmd = 32'h81000010;
    tick();
    check("tmo valid_rise", 32'(cp_if.cp_cmd_valid), 32'd1);
    tick();
    check("tmo in_wait", 32'(cp_if.cp_rsp_ready), 32'd1);
    repeat (15) tick();
    check("tmo pre_expiry", pio_rsp, 32'h40000777);
    tick();
    check("tmo pio_rsp", pio_rsp, 32'hBF000000);
    check("tmo err_bit", 32'(pio_rsp[RSP_ERR_BIT]), 32'd1);
    check("tmo ack_bit", 32'(pio_rsp[RSP_ACK_BIT]), 32'd1);
    tick();

    // Late response held off in IDLE; new command waits for it to drop
    cp_if.cp_rsp_valid = 1'b1;
    cp_if.cp_rsp_data  = 24'hDEAD00;
    cp_if.cp_rsp_stat  = 5'h00;
    pio_cmd = 32'h02000020;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cp_if.cp_cmd_valid || cp_if.cp_rsp_ready) cnt++;
    end
    check("late held_off_cycles", 32'(cnt), 32'd0);
    check("late pio_rsp_unchanged", pio_rsp, 32'hBF000000);
    cp_if.cp_rsp_valid = 1'b0;
    tick();
    check("late issue_after_drain", 32'(cp_if.cp_cmd_valid), 32'd1);
    tick();
    repeat (15) tick();
    check("tc15 busy", pio_rsp, 32'hFF000000);
    cp_if.cp_rsp_valid = 1'b1;
    cp_if.cp_rsp_data  = 24'h000BEE;
    cp_if.cp_rsp_stat  = 5'h00;
    tick();
    cp_if.cp_rsp_valid = 1'b0;
    check("tc15 rsp_wins", pio_rsp, 32'h00000BEE);
    tick();

    // Toggles while busy are dropped; re-toggle after DONE is taken
    pio_cmd = 32'h83000033;
    tick();
    check("tgl valid_rise", 32'(cp_if.cp_cmd_valid), 32'd1);
    tick();
    pio_cmd = 32'h03000099;
    tick();
    pio_cmd = 32'h83000099;
    tick();
    cp_if.cp_rsp_valid = 1'b1;
    cp_if.cp_rsp_data  = 24'h000055;
    cp_if.cp_rsp_stat  = 5'h00;
    tick();
    cp_if.cp_rsp_valid = 1'b0;
    check("tgl pio_rsp", pio_rsp, 32'h80000055);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cp_if.cp_cmd_valid) cnt++;
    end
    check("tgl no_second_issue", 32'(cnt), 32'd0);
    check("tgl opcode_kept", 32'(cp_if.cp_opcode), 32'h03);
    check("tgl arg_kept", 32'(cp_if.cp_arg), 32'h000033);
    run_txn("retgl", 32'h04000044, 2, 24'h000066, 5'h00, 32'h00000066);

    // Reset in WAIT clears everything on the next cycle
    pio_cmd = 32'h86000077;
    tick();
    tick();
    tick();
    check("rst pre_wait", 32'(cp_if.cp_rsp_ready), 32'd1);
    reset   = 1'b1;
    pio_cmd = '0;
    tick();
    check("rst cmd_valid", 32'(cp_if.cp_cmd_valid), 32'd0);
    check("rst rsp_ready", 32'(cp_if.cp_rsp_ready), 32'd0);
    check("rst pio_rsp", pio_rsp, 32'h0);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cp_if.cp_cmd_valid || cp_if.cp_rsp_ready) cnt++;
    end
    check("rst idle_after", 32'(cnt), 32'd0);
    run_txn("stat03", 32'h8B000001, 1, 24'h000123, 5'h03, 32'hA3000123);
    check("stat03 status_field", 32'(pio_rsp[RSP_STAT_LSB +: 5]), 32'h03);
    check("stat03 result_field", 32'(pio_rsp[RSP_RES_LSB +: 24]), 32'h000123);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
